// File: rtl/sequencer_pkg.sv
// Shared types and constants for the exhaustive stimulus sequencer.
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

  // Saturating increment so a long failing sweep never wraps the error count.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Per-vector hold timer: counts 0..HOLD-1, flags the first and last cycle.
module hold_counter #(
  parameter int unsigned HOLD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic last
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  assign first = (cnt == '0);
  assign last  = (cnt == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_vector_sequencer.sv
// Sweeps every WIDTH-bit vector, holds each HOLD cycles and checks the DUT
// response against the golden model on the last hold cycle.
//
//   state | meaning
//   IDLE  | waiting for start, vector parked at 0
//   APPLY | driving vectors, comparing at end of each hold
//   DONE  | sweep finished without abort, last vector held
module multi_vector_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned HOLD  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] expected,
  output logic [WIDTH-1:0] vector,
  output logic             vec_strobe,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] VEC_LAST = '1;

  state_t state, state_nxt;
  logic   hold_first, hold_last;
  logic   start_ok, abort_ok, compare_en, last_vec, mismatch;

  assign start_ok   = (state != APPLY) && start;
  assign abort_ok   = (state == APPLY) && abort;
  assign compare_en = (state == APPLY) && !abort && hold_last;
  assign last_vec   = (vector == VEC_LAST);
  assign mismatch   = (dut_out != expected);

  assign busy       = (state == APPLY);
  assign done       = (state == DONE);
  assign vec_strobe = busy && hold_first;

  hold_counter #(.HOLD(HOLD)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_ok || abort_ok),
    .enable ((state == APPLY) && !abort),
    .first  (hold_first),
    .last   (hold_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = APPLY;
      APPLY: begin
        if (abort)                       state_nxt = IDLE;
        else if (compare_en && last_vec) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vector    <= '0;
      fail      <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        vector    <= '0;
        fail      <= 1'b0;
        err_count <= '0;
      end else if (abort_ok) begin
        vector <= '0;
      end else if (compare_en) begin
        // Last vector is held through DONE rather than wrapping to 0.
        if (!last_vec) vector <= vector + 1'b1;
        if (mismatch) begin
          err_count <= err_inc(err_count);
          fail      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_vector_sequencer.sv
// Bench for multi_vector_sequencer: three configurations on one clock.
module tb_multi_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: WIDTH=2, OUT_W=2, HOLD=20
  logic       start0 = 0, abort0 = 0;
  logic [1:0] dut_out0, exp0, vec0;
  logic       strobe0, busy0, done0, fail0;
  logic [15:0] err0;
  logic [3:0] mis_mask = 4'b0000;
  assign exp0     = ~vec0;
  assign dut_out0 = exp0 ^ {1'b0, mis_mask[vec0]};

  multi_vector_sequencer #(.WIDTH(2), .OUT_W(2), .HOLD(20)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .dut_out(dut_out0), .expected(exp0), .vector(vec0), .vec_strobe(strobe0),
    .busy(busy0), .done(done0), .fail(fail0), .err_count(err0));

  // u1: WIDTH=3, HOLD=1, always matching
  logic       start1 = 0, abort1 = 0;
  logic [3:0] dut_out1 = 4'h5, exp1 = 4'h5;
  logic [2:0] vec1;
  logic       strobe1, busy1, done1, fail1;
  logic [15:0] err1;

  multi_vector_sequencer #(.WIDTH(3), .OUT_W(4), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_out(dut_out1), .expected(exp1), .vector(vec1), .vec_strobe(strobe1),
    .busy(busy1), .done(done1), .fail(fail1), .err_count(err1));

  // u2: WIDTH=16, HOLD=1, mismatching on every vector
  logic        start2 = 0, abort2 = 0;
  logic [0:0]  dut_out2 = 1'b1, exp2 = 1'b0;
  logic [15:0] vec2;
  logic        strobe2, busy2, done2, fail2;
  logic [15:0] err2;

  multi_vector_sequencer #(.WIDTH(16), .OUT_W(1), .HOLD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_out(dut_out2), .expected(exp2), .vector(vec2), .vec_strobe(strobe2),
    .busy(busy2), .done(done2), .fail(fail2), .err_count(err2));

  // Scoreboard for u0: expected vector order, popped on each strobe.
  logic [1:0] exp_q[$];
  int run0 = 0;
  int strobes0 = 0;

  always @(negedge clk) begin
    if (busy0) begin
      if (strobe0) begin
        if (run0 != 0) begin
          n_tests++;
          if (run0 != 20) begin
            n_fail++;
            $display("FAIL hold_len: got %0d cycles, expected 20", run0);
          end
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_vec: got strobe on vector %0d, expected none", vec0);
        end else begin
          logic [1:0] ev;
          ev = exp_q.pop_front();
          if (vec0 !== ev) begin
            n_fail++;
            $display("FAIL strobe_vec: got %0d, expected %0d", vec0, ev);
          end
        end
        run0 = 1;
        strobes0++;
      end else begin
        run0++;
      end
    end else begin
      if (done0 && run0 != 0) begin
        n_tests++;
        if (run0 != 20) begin
          n_fail++;
          $display("FAIL last_hold_len: got %0d cycles, expected 20", run0);
        end
      end
      run0 = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int bound, output int cyc);
    cyc = 1;
    while (!done0 && cyc < bound) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({vec0, strobe0, busy0, done0, fail0, err0} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got vec=%0d strobe=%0b busy=%0b done=%0b fail=%0b err=%0d, expected all 0",
               vec0, strobe0, busy0, done0, fail0, err0);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({busy0, done0, busy1, done1, busy2, done2} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/done not 0, expected 0");
    end
  endtask

  task automatic run_sweep0(input logic [3:0] mask, input int exp_err, input string name);
    int cyc;
    int s0;
    mis_mask = mask;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    s0 = strobes0;
    pulse_start0();
    n_tests++;
    if (busy0 !== 1'b1 || vec0 !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_start: got busy=%0b vec=%0d, expected busy=1 vec=0", name, busy0, vec0);
    end
    wait_done0(200, cyc);
    n_tests++;
    if (cyc != 81) begin
      n_fail++;
      $display("FAIL %s_len: got done after %0d edges, expected 81", name, cyc);
    end
    step();
    n_tests++;
    if (strobes0 - s0 != 4) begin
      n_fail++;
      $display("FAIL %s_strobes: got %0d, expected 4", name, strobes0 - s0);
    end
    n_tests++;
    if ({done0, busy0, fail0, err0, vec0} !== {1'b1, 1'b0, (exp_err != 0), 16'(exp_err), 2'd3}) begin
      n_fail++;
      $display("FAIL %s_end: got done=%0b busy=%0b fail=%0b err=%0d vec=%0d, expected done=1 busy=0 fail=%0b err=%0d vec=3",
               name, done0, busy0, fail0, err0, vec0, (exp_err != 0), exp_err);
    end
  endtask

  task automatic test_abort();
    mis_mask = 4'b0011;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    pulse_start0();
    repeat (29) step();
    abort0 = 1'b1;
    start0 = 1'b1;
    step();
    abort0 = 1'b0;
    start0 = 1'b0;
    n_tests++;
    if ({busy0, done0, vec0, err0, fail0} !== {1'b0, 1'b0, 2'd0, 16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_c30: got busy=%0b done=%0b vec=%0d err=%0d fail=%0b, expected 0 0 0 1 1",
               busy0, done0, vec0, err0, fail0);
    end
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    pulse_start0();
    n_tests++;
    if (err0 !== 16'd0 || fail0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got err=%0d fail=%0b, expected 0 0", err0, fail0);
    end
    repeat (39) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    n_tests++;
    if (err0 !== 16'd1 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_suppress: got err=%0d busy=%0b, expected err=1 busy=0", err0, busy0);
    end
    step();
    n_tests++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_abort: got busy=%0b done=%0b, expected 0 0", busy0, done0);
    end
  endtask

  task automatic test_hold1_restart();
    logic [5:0] got, want;
    start1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c <= 8)       want = {1'b1, 1'b1, 1'b0, 3'(c - 1)};
      else if (c == 9)  want = {1'b0, 1'b0, 1'b1, 3'd7};
      else              want = {1'b1, 1'b1, 1'b0, 3'(c - 10)};
      got = {busy1, strobe1, done1, vec1};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hold1_cycle%0d: got busy/strobe/done/vec=%b, expected %b", c, got, want);
      end
    end
    start1 = 1'b0;
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    n_tests++;
    if (busy1 !== 1'b0 || vec1 !== 3'd0 || err1 !== 16'd0) begin
      n_fail++;
      $display("FAIL hold1_abort: got busy=%0b vec=%0d err=%0d, expected 0 0 0", busy1, vec1, err1);
    end
  endtask

  task automatic test_async_reset();
    mis_mask = 4'b0001;
    exp_q.push_back(2'd0);
    pulse_start0();
    repeat (19) step();
    n_tests++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got %0b, expected 1", busy0);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({vec0, strobe0, busy0, done0, fail0, err0} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got vec=%0d strobe=%0b busy=%0b done=%0b fail=%0b err=%0d, expected all 0",
               vec0, strobe0, busy0, done0, fail0, err0);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({busy0, done0, fail0, err0, vec0} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%0b done=%0b fail=%0b err=%0d vec=%0d, expected all 0",
               busy0, done0, fail0, err0, vec0);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 70000) begin
      step();
      cyc++;
    end
    n_tests++;
    if (cyc != 65537) begin
      n_fail++;
      $display("FAIL sat_len: got done after %0d edges, expected 65537", cyc);
    end
    repeat (5) step();
    n_tests++;
    if ({err2, fail2, done2, vec2} !== {16'hFFFF, 1'b1, 1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL saturation: got err=%0h fail=%0b done=%0b vec=%0h, expected ffff 1 1 ffff",
               err2, fail2, done2, vec2);
    end
  endtask

  initial begin
    test_reset();
    run_sweep0(4'b0000, 0, "clean");
    run_sweep0(4'b1010, 2, "mismatch");
    test_abort();
    test_hold1_restart();
    test_async_reset();
    test_saturation();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
